// File: rtl/fifo_rd_unpacker.sv
// rtl/fifo_rd_unpacker.sv - FIFO read unpacker: IN_W line to OUT_W valid/ready beats
//
// Reads 128-bit lines from a sync FIFO with 1-cycle read latency. It holds up to two lines,
// counting lines in flight, and emits each line as IN_W/OUT_W beats, LSB beat first.
// The optional o_tpar port is enabled by the macro FIFO_UNPACK_PARITY_EN.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   o_rden       FIFO read strobe (combinational, never while i_empty)
//   i_empty      FIFO empty flag
//   i_rddata     FIFO read data, valid the cycle after o_rden
//   o_tdata      beat data, zero while o_tvalid is low
//   o_tvalid     beat valid
//   i_tready     sink ready
//   o_tlast      final beat of a line
//   i_flush      drop buffered lines and any in-flight read
//   o_busy       line buffered, read in flight, or dropped return pending
//   o_tpar       even parity of o_tdata (FIFO_UNPACK_PARITY_EN only)
module fifo_rd_unpacker #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             o_rden,
    input  logic             i_empty,
    input  logic [IN_W-1:0]  i_rddata,
    output logic [OUT_W-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast,
    input  logic             i_flush,
    output logic             o_busy
`ifdef FIFO_UNPACK_PARITY_EN
    ,
    output logic             o_tpar
`endif
);

    localparam int BEATS = IN_W / OUT_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    generate
        if ((IN_W % OUT_W) != 0 || BEATS < 2) begin : g_bad_cfg
            $error("fifo_rd_unpacker: IN_W must be a multiple of OUT_W with at least two beats");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             r_occ;
    logic             r_pending;
    logic             r_discard;
    logic [IDX_W-1:0] r_idx;
    logic [IN_W-1:0]  r_head;
    logic [IN_W-1:0]  r_tail;

    occ_t             w_occ_next;
    logic [1:0]       w_inflight;
    logic             w_xfer;
    logic             w_retire;
    logic             w_capture;
    logic             w_cap_to_head;

    // Buffered plus in-flight lines; capped at two so a capture always finds a free slot.
    assign w_inflight = r_occ + {1'b0, r_pending};
    assign o_rden     = !reset && !i_empty && !i_flush && (w_inflight < 2'd2);

    assign o_tvalid   = (r_occ != EMPTY);
    assign o_tdata    = o_tvalid ? r_head[r_idx*OUT_W +: OUT_W] : '0;
    assign o_tlast    = o_tvalid && (r_idx == LAST_IDX);
    assign o_busy     = o_tvalid || r_pending || r_discard;

`ifdef FIFO_UNPACK_PARITY_EN
    assign o_tpar     = ^o_tdata;
`endif

    assign w_xfer     = o_tvalid && i_tready;
    assign w_retire   = w_xfer && o_tlast;
    // A flush in the return cycle drops the returning line instead of capturing it.
    assign w_capture  = r_pending && !i_flush;
    // The returning line lands in the head slot when the head is empty or is being retired.
    assign w_cap_to_head = (r_occ == EMPTY) || ((r_occ == ONE) && w_retire);

    always_comb begin
        w_occ_next = r_occ;
        if (w_retire && !w_capture) begin
            w_occ_next = (r_occ == TWO) ? ONE : EMPTY;
        end else if (w_capture && !w_retire) begin
            w_occ_next = (r_occ == EMPTY) ? ONE : TWO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ     <= EMPTY;
            r_pending <= 1'b0;
            r_discard <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_pending <= o_rden;
            // Flags the cycle after a flush that swallowed a returning line.
            r_discard <= i_flush && r_pending;
            if (i_flush) begin
                r_occ <= EMPTY;
                r_idx <= '0;
            end else begin
                r_occ <= w_occ_next;
                if (w_retire) begin
                    r_idx  <= '0;
                    r_head <= r_tail;
                end else if (w_xfer) begin
                    r_idx <= r_idx + 1'b1;
                end
                // Placed after the shift so a same-cycle capture into the head wins.
                if (w_capture) begin
                    if (w_cap_to_head) begin
                        r_head <= i_rddata;
                    end else begin
                        r_tail <= i_rddata;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(w_capture && r_occ == TWO));
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb/tb_fifo_rd_unpacker.sv - self-checking bench for fifo_rd_unpacker
module tb_fifo_rd_unpacker;

    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int BEATS = IN_W / OUT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset    = 1'b1;
    logic             i_empty  = 1'b1;
    logic             i_tready = 1'b0;
    logic             i_flush  = 1'b0;
    logic [IN_W-1:0]  i_rddata = '0;
    logic             o_rden, o_tvalid, o_tlast, o_busy;
    logic [OUT_W-1:0] o_tdata;
`ifdef FIFO_UNPACK_PARITY_EN
    logic             o_tpar;
`endif

    fifo_rd_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .o_rden   (o_rden),
        .i_empty  (i_empty),
        .i_rddata (i_rddata),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_tlast  (o_tlast),
        .i_flush  (i_flush),
        .o_busy   (o_busy)
`ifdef FIFO_UNPACK_PARITY_EN
        ,
        .o_tpar   (o_tpar)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [IN_W-1:0]  src_q[$];
    logic [IN_W-1:0]  rd_next;
    bit               rd_valid = 0;
    logic [OUT_W-1:0] exp_data[$];
    bit               exp_last[$];

    task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Source FIFO: a popped line appears on i_rddata the following cycle; otherwise junk.
    always @(posedge clk) begin
        #2;
        i_rddata = rd_valid ? rd_next : {$urandom, $urandom, $urandom, $urandom};
        rd_valid = 0;
        i_empty  = (src_q.size() == 0);
    end

    // Reference model: every line read becomes BEATS expected beats; flush/reset drop them all.
    bit               p_stall = 0;
    logic [OUT_W-1:0] p_data;
    bit               p_last;
    always @(negedge clk) begin
        if (reset) begin
            check("rden_in_reset", o_rden, 0);
            exp_data.delete();
            exp_last.delete();
            p_stall = 0;
        end else begin
            if (p_stall) begin
                check("stall_valid", o_tvalid, 1);
                check("stall_data", o_tdata, p_data);
                check("stall_last", o_tlast, p_last);
            end
            if (o_rden) check("rden_while_empty", i_empty, 0);
            if (o_tvalid && i_tready) begin
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", o_tdata);
                end else begin
                    check("beat_data", o_tdata, exp_data[0]);
                    check("beat_last", o_tlast, exp_last[0]);
`ifdef FIFO_UNPACK_PARITY_EN
                    check("beat_par", o_tpar, ^exp_data[0]);
`endif
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
            end
`ifdef FIFO_UNPACK_PARITY_EN
            if (!o_tvalid) check("idle_par", o_tpar, 0);
`endif
            p_stall = o_tvalid && !i_tready && !i_flush;
            p_data  = o_tdata;
            p_last  = o_tlast;
            if (i_flush) begin
                check("rden_in_flush", o_rden, 0);
                exp_data.delete();
                exp_last.delete();
            end
            if (o_rden && src_q.size() > 0) begin
                rd_next  = src_q.pop_front();
                rd_valid = 1;
                for (int b = 0; b < BEATS; b++) begin
                    exp_data.push_back(rd_next[b*OUT_W +: OUT_W]);
                    exp_last.push_back(b == BEATS - 1);
                end
            end
            check("lines_held_le_2", ((exp_data.size() + BEATS - 1) / BEATS) <= 2, 1);
        end
    end

    task automatic wait_xfer(input string name, output logic [OUT_W-1:0] d);
        bit got;
        got = 0;
        d   = '0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_tvalid && i_tready) begin
                got = 1;
                d   = o_tdata;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no beat within 20 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        @(posedge clk);
        #1;
        i_flush  = 0;
        i_tready = 1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk);
            #1;
            done = (src_q.size() == 0) && (exp_data.size() == 0) && !o_busy;
        end
        check(name, done, 1);
    endtask

    typedef struct packed {
        logic [IN_W-1:0]            line;
        logic [BEATS-1:0][OUT_W-1:0] beats;
        logic [BEATS-1:0]           last_mask;
    } vec_t;

    vec_t             tab[4];
    logic [OUT_W-1:0] d;
    logic [IN_W-1:0]  ln;
    logic [OUT_W-1:0] exp_first;

    initial begin
        tab[0].line  = 128'h00000004_00000003_00000002_00000001;
        tab[0].beats = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
        tab[1].line  = {128{1'b1}};
        tab[1].beats = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tab[2].line  = 128'hDEADBEEF_CAFEF00D_12345678_A5A5A5A5;
        tab[2].beats = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'hA5A5A5A5};
        tab[3].line  = 128'h80000000_00000000_00000000_00000001;
        tab[3].beats = {32'h80000000, 32'h00000000, 32'h00000000, 32'h00000001};
        for (int i = 0; i < 4; i++) tab[i].last_mask = 4'b1000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rden", o_rden, 0);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tlast", o_tlast, 0);
        check("rst_busy", o_busy, 0);
        check("rst_tdata", o_tdata, 0);
        @(posedge clk);
        #1;
        reset    = 0;
        i_tready = 1;
        @(negedge clk);
        check("idle_tvalid", o_tvalid, 0);
        check("idle_busy", o_busy, 0);

        // Single lines: read at t, gap at t+1, beats on t+2..t+5, idle after.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            src_q.push_back(tab[i].line);
            @(negedge clk);
            check("lat_rden", o_rden, 1);
            check("lat_t0_valid", o_tvalid, 0);
            @(negedge clk);
            check("lat_t1_valid", o_tvalid, 0);
            check("lat_t1_busy", o_busy, 1);
            for (int b = 0; b < BEATS; b++) begin
                @(negedge clk);
                check("tab_valid", o_tvalid, 1);
                check("tab_data", o_tdata, tab[i].beats[b]);
                check("tab_last", o_tlast, tab[i].last_mask[b]);
            end
            @(negedge clk);
            check("tab_busy_done", o_busy, 0);
            check("tab_valid_done", o_tvalid, 0);
        end

`ifdef FIFO_UNPACK_PARITY_EN
        @(posedge clk);
        #1;
        src_q.push_back(128'h00000000_00000000_00000003_00000007);
        repeat (3) @(negedge clk);
        check("par_data7", o_tdata, 32'h7);
        check("par_7", o_tpar, 1);
        @(negedge clk);
        check("par_data3", o_tdata, 32'h3);
        check("par_3", o_tpar, 0);
        drain("par_drain");
`endif

        // Backpressure from beat 2 for 10 cycles.
        @(posedge clk);
        #1;
        src_q.push_back(128'h00000004_00000003_00000002_00000001);
        src_q.push_back(128'h00000014_00000013_00000012_00000011);
        src_q.push_back(128'h00000024_00000023_00000022_00000021);
        wait_xfer("bp_first", d);
        check("bp_first_beat", d, 32'h1);
        @(posedge clk);
        #1;
        i_tready = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_valid", o_tvalid, 1);
            check("bp_hold_data", o_tdata, 32'h2);
        end
        check("bp_rden_stopped", o_rden, 0);
        check("bp_src_nonempty", i_empty, 0);
        @(posedge clk);
        #1;
        i_tready = 1;
        @(negedge clk);
        check("bp_resume2", o_tdata, 32'h2);
        @(negedge clk);
        check("bp_resume3", o_tdata, 32'h3);
        drain("bp_drain");

        // Flush the cycle after a read, with one line buffered.
        @(posedge clk);
        #1;
        i_tready = 0;
        src_q.push_back(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        src_q.push_back(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
        src_q.push_back(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
        @(negedge clk);
        check("fl_rden", o_rden, 1);
        check("fl_valid_before", o_tvalid, 1);
        @(posedge clk);
        #1;
        i_flush = 1;
        @(posedge clk);
        #1;
        i_flush  = 0;
        i_tready = 1;
        @(negedge clk);
        check("fl_valid_cleared", o_tvalid, 0);
        check("fl_rden_after", o_rden, 1);
        wait_xfer("fl_next", d);
        check("fl_next_beat0", d, 32'hC0C0C0C0);
        drain("fl_drain");

        // Reset after the first beat of a line.
        @(posedge clk);
        #1;
        src_q.push_back(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        src_q.push_back(128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0);
        wait_xfer("rs_first", d);
        check("rs_first_beat", d, 32'hD0D0D0D0);
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rs_tvalid", o_tvalid, 0);
        check("rs_tlast", o_tlast, 0);
        check("rs_busy", o_busy, 0);
        check("rs_tdata", o_tdata, 0);
        @(posedge clk);
        #1;
        reset = 0;
        ln = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
        exp_first = (src_q.size() > 0) ? src_q[0][OUT_W-1:0] : ln[OUT_W-1:0];
        src_q.push_back(ln);
        wait_xfer("rs_after", d);
        check("rs_after_beat0", d, exp_first);
        drain("rs_drain");

        // Eight lines back to back: 32 beats with no bubble.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
        wait_xfer("b2b_first", d);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            check("b2b_valid", o_tvalid, 1);
            check("b2b_last", o_tlast, (k % BEATS) == BEATS - 1);
        end
        drain("b2b_drain");

        // Randomised traffic, ready and flush.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            i_tready = ($urandom % 10) < 7;
            i_flush  = ($urandom % 50) == 0;
            if (($urandom % 3) == 0 && src_q.size() < 6)
                src_q.push_back({$urandom, $urandom, $urandom, $urandom});
        end
        drain("rnd_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
